// File: rtl/spi_reg_cmd_parser_pkg.sv
// Shared types for the SPI register command parser: register-file data and
// address types, the command write-bit index, and the command FSM states.
package regPKG;
  typedef logic [15:0] reg_data_t;
  typedef logic [6:0]  reg_addr_t;
  localparam int CMD_WR_BIT = 7;
endpackage

package spiPKG;
  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_WR_HI,
    S_WR_LO,
    S_RD_FETCH,
    S_RD_CAP,
    S_RD_HI,
    S_RD_LO,
    S_DRAIN
  } cmd_state_t;
endpackage

// File: rtl/spi_reg_cmd_parser.sv
// Turns framed SPI command bytes into register write/read strobes and returns
// read data as MISO bytes. Define SPI_CMD_AUTOINC_EN for burst (auto-increment) frames.
module spi_reg_cmd_parser
  import regPKG::*;
  import spiPKG::*;
#(
  parameter int unsigned ADDR_W  = 7,
  parameter logic [7:0]  IDLE_TX = 8'h00
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              frame_active,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [15:0]       reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [15:0]       reg_rdata,
  output logic              frame_err
);

`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  cmd_state_t        state, state_d;
  logic [ADDR_W-1:0] addr_d;
  reg_data_t         wdata_d;
  logic [7:0]        tx_d;
  logic              we_d, re_d, err_d;
  logic [7:0]        wr_hi, wr_hi_d;
  logic [7:0]        rd_lo, rd_lo_d;

  always_comb begin
    state_d = state;
    addr_d  = reg_addr;
    wdata_d = reg_wdata;
    tx_d    = tx_byte;
    wr_hi_d = wr_hi;
    rd_lo_d = rd_lo;
    we_d    = 1'b0;
    err_d   = 1'b0;

    // A burst write advances the address only after its strobe cycle, so the
    // register file sees a stable address while reg_we is high.
    if (AUTOINC && reg_we) addr_d = reg_addr + ADDR_ONE;

    case (state)
      S_IDLE: begin
        if (frame_active) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          addr_d  = rx_byte[ADDR_W-1:0];
          state_d = rx_byte[CMD_WR_BIT] ? S_WR_HI : S_RD_FETCH;
        end
      end
      S_WR_HI: begin
        if (rx_valid) begin
          wr_hi_d = rx_byte;
          state_d = S_WR_LO;
        end
      end
      S_WR_LO: begin
        if (rx_valid) begin
          wdata_d = {wr_hi, rx_byte};
          we_d    = 1'b1;
          state_d = AUTOINC ? S_WR_HI : S_DRAIN;
        end else if (!frame_active) begin
          err_d = 1'b1;
        end
      end
      S_RD_FETCH: begin
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        tx_d    = reg_rdata[15:8];
        rd_lo_d = reg_rdata[7:0];
        state_d = S_RD_HI;
      end
      S_RD_HI: begin
        if (rx_valid) begin
          tx_d    = rd_lo;
          state_d = S_RD_LO;
        end
      end
      S_RD_LO: begin
        if (rx_valid) begin
          tx_d = IDLE_TX;
          if (AUTOINC) begin
            addr_d  = reg_addr + ADDR_ONE;
            state_d = S_RD_FETCH;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DRAIN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame end wins over the byte-level transition, after the byte has been used.
    if (!frame_active) begin
      state_d = S_IDLE;
      tx_d    = IDLE_TX;
    end

    re_d = (state_d == S_RD_FETCH);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= S_IDLE;
      tx_byte   <= IDLE_TX;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      tx_byte   <= tx_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
      reg_we    <= we_d;
      reg_re    <= re_d;
      frame_err <= err_d;
    end
  end

  always_ff @(posedge clk_in) begin
    wr_hi <= wr_hi_d;
    rd_lo <= rd_lo_d;
  end

endmodule

// File: tb/tb_spi_reg_cmd_parser.sv
// Bench for spi_reg_cmd_parser: frame-level protocol model predicts strobes and
// MISO bytes per cycle; literal checks pin the expected register traffic.
module tb_spi_reg_cmd_parser;
  localparam logic [7:0] IDLE = 8'h5A;
  localparam int NCYC = 4096;
  localparam int GAP  = 6;
`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        frame_active;
  logic [7:0]  tx_byte;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        frame_err;

  spi_reg_cmd_parser #(.ADDR_W(7), .IDLE_TX(IDLE)) dut (
    .clk_in(clk_in), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_active(frame_active), .tx_byte(tx_byte), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .frame_err(frame_err)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  logic        exp_we   [NCYC];
  logic        exp_re   [NCYC];
  logic        exp_err  [NCYC];
  logic [7:0]  exp_tx   [NCYC];
  logic [6:0]  exp_addr [NCYC];
  logic [15:0] exp_wdata[NCYC];

  int          we_cnt = 0, re_cnt = 0, err_cnt = 0;
  logic [6:0]  we_addr_log[$];
  logic [15:0] we_data_log[$];
  logic [7:0]  tx_hist[$];
  logic [7:0]  tx_prev = IDLE;
  logic [7:0]  fq[$];

  function automatic logic [15:0] rd_value(input logic [6:0] a);
    if (a == 7'h05) return 16'hBEEF;
    return {1'b0, a, 8'hC3 ^ {1'b0, a}};
  endfunction

  function automatic logic [7:0] hist(input int i);
    if (i < tx_hist.size()) return tx_hist[i];
    return 8'hFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fill_tx(input int from, input logic [7:0] v);
    for (int i = from; i < NCYC; i++) exp_tx[i] = v;
  endtask

  // A fetch issued in cycle c returns its high byte on MISO from c+2 onward.
  task automatic sched_fetch(input int c, input logic [6:0] a);
    logic [15:0] d;
    d = rd_value(a);
    exp_re[c]   = 1'b1;
    exp_addr[c] = a;
    fill_tx(c + 2, d[15:8]);
  endtask

  // Drives the bytes in fq as one frame and records the expected DUT behaviour.
  task automatic run_frame(input bit coincide);
    int          t, n, j, fend;
    bit          is_wr;
    logic [6:0]  base;
    logic [7:0]  hi;
    logic [15:0] d;
    is_wr = 1'b0; base = '0; hi = '0; fend = 0;
    n = fq.size();
    frame_active = 1'b1;
    idle(2);
    for (int k = 0; k < n; k++) begin
      t = cyc;
      rx_valid = 1'b1;
      rx_byte  = fq[k];
      if (k == 0) begin
        is_wr = fq[0][7];
        base  = fq[0][6:0];
        if (!is_wr) sched_fetch(t + 1, base);
      end else if (is_wr) begin
        if (k % 2 == 1) hi = fq[k];
        else if (AUTOINC || k == 2) begin
          exp_we[t + 1]    = 1'b1;
          exp_addr[t + 1]  = 7'(base + (k - 2) / 2);
          exp_wdata[t + 1] = {hi, fq[k]};
        end
      end else begin
        j = (k - 1) / 2;
        if (AUTOINC || j == 0) begin
          if (k % 2 == 1) begin
            d = rd_value(7'(base + j));
            fill_tx(t + 1, d[7:0]);
          end else begin
            fill_tx(t + 1, IDLE);
            if (AUTOINC) sched_fetch(t + 1, 7'(base + j + 1));
          end
        end
      end
      if (coincide && k == n - 1) begin
        frame_active = 1'b0;
        fend = t;
      end
      tick();
      rx_valid = 1'b0;
      idle(GAP - 1);
    end
    if (!coincide) begin
      frame_active = 1'b0;
      fend = cyc;
      if (is_wr && n >= 2 && n % 2 == 0 && (AUTOINC || n == 2)) exp_err[fend + 1] = 1'b1;
    end
    fill_tx(fend + 1, IDLE);
    idle(GAP);
  endtask

  // Register-file stub: read data valid exactly one cycle after reg_re.
  initial begin
    logic       re_s;
    logic [6:0] a_s;
    reg_rdata = 16'hDEAD;
    forever begin
      @(negedge clk_in);
      re_s = reg_re;
      a_s  = reg_addr;
      @(posedge clk_in);
      #1;
      reg_rdata = re_s ? rd_value(a_s) : 16'hDEAD;
    end
  end

  // Per-cycle compare against the model, plus event logging for literal checks.
  initial begin
    forever begin
      @(negedge clk_in);
      if (cmp_on && cyc < NCYC) begin
        chk("reg_we", 32'(reg_we), 32'(exp_we[cyc]));
        chk("reg_re", 32'(reg_re), 32'(exp_re[cyc]));
        chk("frame_err", 32'(frame_err), 32'(exp_err[cyc]));
        chk("tx_byte", 32'(tx_byte), 32'(exp_tx[cyc]));
        if (exp_we[cyc] || exp_re[cyc]) chk("reg_addr", 32'(reg_addr), 32'(exp_addr[cyc]));
        if (exp_we[cyc]) chk("reg_wdata", 32'(reg_wdata), 32'(exp_wdata[cyc]));
      end
      if (cmp_on) begin
        if (reg_we) begin
          we_cnt++;
          we_addr_log.push_back(reg_addr);
          we_data_log.push_back(reg_wdata);
        end
        if (reg_re) re_cnt++;
        if (frame_err) err_cnt++;
        if (tx_byte != tx_prev) tx_hist.push_back(tx_byte);
        tx_prev = tx_byte;
      end
    end
  end

  initial begin
    int w0, r0, e0, i0;
    for (int i = 0; i < NCYC; i++) begin
      exp_we[i] = 1'b0; exp_re[i] = 1'b0; exp_err[i] = 1'b0;
      exp_tx[i] = IDLE; exp_addr[i] = '0; exp_wdata[i] = '0;
    end
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; frame_active = 1'b0;
    idle(3);
    cmp_on = 1'b1;
    chk("rst_tx", 32'(tx_byte), 32'(IDLE));
    chk("rst_addr", 32'(reg_addr), 32'h0);
    chk("rst_wdata", 32'(reg_wdata), 32'h0);
    reset = 1'b0;
    idle(3);

    // Single write
    w0 = we_cnt;
    fq = '{8'h85, 8'h12, 8'h34};
    run_frame(1'b0);
    chk("wr1_count", 32'(we_cnt - w0), 32'd1);
    chk("wr1_addr", 32'(we_addr_log[$]), 32'h05);
    chk("wr1_data", 32'(we_data_log[$]), 32'h1234);

    // Single read
    r0 = re_cnt; i0 = tx_hist.size();
    fq = '{8'h05, 8'h00, 8'h00};
    run_frame(1'b0);
    chk("rd1_re_count", 32'(re_cnt - r0), AUTOINC ? 32'd2 : 32'd1);
    chk("rd1_tx_hi", 32'(hist(i0)), 32'hBE);
    chk("rd1_tx_lo", 32'(hist(i0 + 1)), 32'hEF);
    chk("rd1_tx_idle", 32'(hist(i0 + 2)), 32'(IDLE));

    // Burst write across the address wrap
    w0 = we_cnt;
    fq = '{8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(1'b0);
    if (AUTOINC) begin
      chk("burst_wr_count", 32'(we_cnt - w0), 32'd2);
      chk("burst_wr_addr0", 32'(we_addr_log[we_addr_log.size() - 2]), 32'h7F);
      chk("burst_wr_data0", 32'(we_data_log[we_data_log.size() - 2]), 32'hAABB);
      chk("burst_wr_addr1", 32'(we_addr_log[$]), 32'h00);
      chk("burst_wr_data1", 32'(we_data_log[$]), 32'hCCDD);
    end else begin
      chk("burst_wr_count", 32'(we_cnt - w0), 32'd1);
      chk("burst_wr_addr0", 32'(we_addr_log[$]), 32'h7F);
      chk("burst_wr_data0", 32'(we_data_log[$]), 32'hAABB);
    end

    // Frame dropped with the low byte missing
    w0 = we_cnt; e0 = err_cnt;
    fq = '{8'h81, 8'h55};
    run_frame(1'b0);
    chk("drop_we_count", 32'(we_cnt - w0), 32'd0);
    chk("drop_err_count", 32'(err_cnt - e0), 32'd1);

    // Low byte coincident with frame end still writes, no error
    w0 = we_cnt; e0 = err_cnt;
    fq = '{8'h90, 8'h01, 8'h02};
    run_frame(1'b1);
    chk("coin_we_count", 32'(we_cnt - w0), 32'd1);
    chk("coin_addr", 32'(we_addr_log[$]), 32'h10);
    chk("coin_data", 32'(we_data_log[$]), 32'h0102);
    chk("coin_err_count", 32'(err_cnt - e0), 32'd0);

    // Burst read across the address wrap
    r0 = re_cnt;
    fq = '{8'h7F, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(1'b0);
    chk("burst_rd_re_count", 32'(re_cnt - r0), AUTOINC ? 32'd3 : 32'd1);

    // Byte outside a frame is ignored
    w0 = we_cnt; r0 = re_cnt;
    rx_valid = 1'b1; rx_byte = 8'h85;
    tick();
    rx_valid = 1'b0;
    idle(GAP);
    chk("idle_rx_we", 32'(we_cnt - w0), 32'd0);
    chk("idle_rx_re", 32'(re_cnt - r0), 32'd0);

    // Reset between high and low data bytes
    w0 = we_cnt; e0 = err_cnt;
    frame_active = 1'b1;
    idle(2);
    rx_valid = 1'b1; rx_byte = 8'h83; tick(); rx_valid = 1'b0; idle(GAP - 1);
    rx_valid = 1'b1; rx_byte = 8'h11; tick(); rx_valid = 1'b0; idle(GAP - 1);
    reset = 1'b1; frame_active = 1'b0;
    idle(2);
    chk("mid_rst_tx", 32'(tx_byte), 32'(IDLE));
    chk("mid_rst_addr", 32'(reg_addr), 32'h0);
    chk("mid_rst_wdata", 32'(reg_wdata), 32'h0);
    reset = 1'b0;
    idle(3);
    chk("mid_rst_we_count", 32'(we_cnt - w0), 32'd0);
    chk("mid_rst_err_count", 32'(err_cnt - e0), 32'd0);
    fq = '{8'h8A, 8'h0F, 8'hF0};
    run_frame(1'b0);
    chk("post_rst_we_count", 32'(we_cnt - w0), 32'd1);
    chk("post_rst_addr", 32'(we_addr_log[$]), 32'h0A);
    chk("post_rst_data", 32'(we_data_log[$]), 32'h0FF0);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
